wddl_rail_decoder: RTL and testbench
====================================

// Module: wddl_rail_decoder
// PURPOSE
// - Receiving end of the WDDL dual-rail datapath: sequences precharge/evaluate
//   phases for the upstream dual-rail gate network, samples the settled rails,
//   checks rail validity and converts the result to single-rail data.
// - Sits at the output boundary of a protected dual-rail region, e.g. after an
//   S-box built from dual-rail AND/OR/INV cells. Presents a valid/ready stream
//   to single-rail logic.
// PARAMETERS
// - WIDTH       8  number of dual-rail bits decoded
// - PRE_CYCLES  2  clock cycles in precharge phase (>=1)
// - EVAL_CYCLES 2  clock cycles in evaluate phase (>=1); rails sampled on last
// PORTS
// - clk        in   1      system clock; all state changes on rising edge
// - rst_n      in   1      reset: synchronous, active-low
// - start      in   1      1-cycle request to run one precharge/evaluate round
// - busy       out  1      high from start acceptance until output handshake
// - prech      out  1      1 = precharge phase (upstream drives all rails to 0)
// - din_t      in   WIDTH  true rails from dual-rail network
// - din_f      in   WIDTH  false rails from dual-rail network
// - out_data   out  WIDTH  decoded single-rail data (zeroed on any fault)
// - out_err    out  2      [0] precharge fault, [1] rail fault; valid with out_valid
// - out_valid  out  1      result available
// - out_ready  in   1      downstream accepts result when out_valid & out_ready
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state IDLE, counter 0, prech=1, busy=0,
//   out_valid=0, out_data=0, out_err=0. Reset mid-round discards the round.
// - FSM: IDLE -> PRECH -> EVAL -> HOLD -> IDLE.
// - IDLE: prech=1. start=1 -> PRECH, counter cleared, busy=1 next cycle.
// - PRECH: prech=1 for PRE_CYCLES cycles. On last cycle, if any din_t|din_f bit
//   is 1, latch err[0]=1. Then -> EVAL.
// - EVAL: prech=0 for EVAL_CYCLES cycles. On last cycle, sample rails per bit:
//   t=1,f=0 -> 1; t=0,f=1 -> 0; 00 (incomplete) or 11 (collision) -> err[1]=1.
// - EVAL exit -> HOLD, out_valid=1 in the same edge as the register update.
//   out_data = decoded bits when out_err==0, else all-zero.
// - HOLD: prech=1 (re-precharge immediately so the network does not hold the
//   value). Outputs stable until out_valid&out_ready, then -> IDLE, out_valid=0.
// - start while busy=1: ignored, not queued.
// - start on the same cycle as the HOLD handshake: ignored; requester retries.
// - Latency: start at cycle 0 -> out_valid first high at cycle
//   1+PRE_CYCLES+EVAL_CYCLES.
// - Counter width is $clog2 of max(PRE_CYCLES,EVAL_CYCLES)+1. Counter reloads
//   to 0 on every state change.
// - err bits are sticky for the round; cleared on entry to PRECH.
// - Data and rails are never combinationally forwarded: out_data is registered
//   only.
// STRUCTURE
// - Shared package wddl_pkg: state enum constants (ST_IDLE, ST_PRECH, ST_EVAL,
//   ST_HOLD), err bit indices ERR_PRECH=0, ERR_RAIL=1.
// - One natural sub-module: wddl_bit_check (per-bit t/f -> data, invalid flag),
//   instantiated WIDTH times in a generate loop; FSM and counter stay in top.
// TESTING
// - Nominal: WIDTH=8, rails encode 8'hA5 in EVAL, zeros in PRECH, start pulse
//   -> out_valid at cycle 5, out_data=8'hA5, out_err=2'b00.
// - Backpressure: out_ready=0 for 10 cycles -> out_valid, out_data held stable,
//   prech=1 throughout HOLD; handshake -> IDLE next cycle.
// - Rail fault: bit 3 driven 11, bit 0 driven 00 in EVAL
//   -> out_err=2'b10, out_data=8'h00.
// - Precharge fault: din_t[7]=1 on last PRECH cycle, clean EVAL
//   -> out_err=2'b01, out_data=0.
// - start pulsed during PRECH/EVAL/HOLD -> no extra round; busy=1 throughout;
//   one result only.
// - rst_n=0 during EVAL -> next edge: IDLE, prech=1, out_valid=0; new start
//   runs a clean round.

Source files
------------

// File: rtl/wddl_pkg.sv
// rtl/wddl_pkg.sv - shared state encoding and error bit indices for the WDDL rail decoder
package wddl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRECH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int ERR_PRECH = 0;
  localparam int ERR_RAIL  = 1;

endpackage

// File: rtl/wddl_bit_check.sv
// rtl/wddl_bit_check.sv - one dual-rail bit to single-rail data plus invalid (00/11) flag
module wddl_bit_check (
  input  logic rail_t,
  input  logic rail_f,
  output logic data,
  output logic invalid
);

  assign data    = rail_t;
  assign invalid = ~(rail_t ^ rail_f);

endmodule

// File: rtl/wddl_rail_decoder.sv
// rtl/wddl_rail_decoder.sv - precharge/evaluate sequencer, rail sampler and single-rail stream output
module wddl_rail_decoder
  import wddl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PRE_CYCLES  = 2,
  parameter int EVAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             prech,
  input  logic [WIDTH-1:0] din_t,
  input  logic [WIDTH-1:0] din_f,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MAX_CYC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] dec_data;
  logic [WIDTH-1:0] dec_invalid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wddl_bit_check u_bit (
      .rail_t  (din_t[i]),
      .rail_f  (din_f[i]),
      .data    (dec_data[i]),
      .invalid (dec_invalid[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRECH;
          cnt_d   = '0;
          err_d   = '0;
        end
      end
      ST_PRECH: begin
        if (cnt_q == PRE_LAST) begin
          state_d          = ST_EVAL;
          cnt_d            = '0;
          err_d[ERR_PRECH] = err_q[ERR_PRECH] | (|(din_t | din_f));
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        if (cnt_q == EVAL_LAST) begin
          state_d         = ST_HOLD;
          cnt_d           = '0;
          err_d[ERR_RAIL] = err_q[ERR_RAIL] | (|dec_invalid);
          out_valid_d     = 1'b1;
          // Faulty rounds must not leak partially decoded data downstream.
          out_data_d      = (err_d == 2'b00) ? dec_data : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Only EVAL releases the rails; HOLD re-precharges so the network never retains the value.
  assign prech     = (state_q != ST_EVAL);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_wddl_rail_decoder.sv
// tb/tb_wddl_rail_decoder.sv - directed self-checking bench for wddl_rail_decoder
module tb_wddl_rail_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] din_t, din_f;
  logic       busy, prech, out_valid;
  logic [7:0] out_data;
  logic [1:0] out_err;

  logic [7:0] pre_t = 8'h00, pre_f = 8'h00, ev_t = 8'h00, ev_f = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Emulates the upstream dual-rail network following the phase signal.
  assign din_t = prech ? pre_t : ev_t;
  assign din_f = prech ? pre_f : ev_f;

  wddl_rail_decoder #(.WIDTH(8), .PRE_CYCLES(2), .EVAL_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .prech     (prech),
    .din_t     (din_t),
    .din_f     (din_f),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_round(input logic [7:0] et, input logic [7:0] ef, input logic [7:0] pt,
                           input logic [7:0] exp_d, input logic [1:0] exp_e,
                           input int stall, input bit hold_start);
    int  lat;
    bit  got;
    ev_t  = et;
    ev_f  = ef;
    pre_t = pt;
    pre_f = 8'h00;
    start = 1'b1;
    lat   = 0;
    got   = 0;
    while (lat < 20 && !got) begin
      step();
      lat++;
      if (!hold_start) start = 1'b0;
      if (lat == 1) check_eq("busy_after_start", busy, 1);
      if (out_valid) got = 1;
    end
    check_eq("latency", lat, 5);
    check_eq("out_data", out_data, exp_d);
    check_eq("out_err", out_err, exp_e);
    check_eq("prech_hold", prech, 1);
    for (int i = 0; i < stall; i++) begin
      step();
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, exp_d);
      check_eq("stall_prech", prech, 1);
      check_eq("stall_busy", busy, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    pre_t     = 8'h00;
    check_eq("handshake_valid", out_valid, 0);
    check_eq("handshake_busy", busy, 0);
    if (hold_start) begin
      for (int i = 0; i < 6; i++) begin
        step();
        check_eq("no_extra_busy", busy, 0);
        check_eq("no_extra_valid", out_valid, 0);
      end
    end
  endtask

  initial begin
    step();
    step();
    check_eq("rst_prech", prech, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_err", out_err, 0);
    rst_n = 1'b1;
    step();

    run_round(8'hA5, 8'h5A, 8'h00, 8'hA5, 2'b00, 0, 1'b0);
    run_round(8'h96, 8'h69, 8'h00, 8'h96, 2'b00, 10, 1'b0);
    run_round(8'hAC, 8'h5A, 8'h00, 8'h00, 2'b10, 0, 1'b0);
    run_round(8'h3C, 8'hC3, 8'h80, 8'h00, 2'b01, 0, 1'b0);
    run_round(8'h0F, 8'hF0, 8'h00, 8'h0F, 2'b00, 3, 1'b1);

    ev_t  = 8'hA5;
    ev_f  = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("mid_eval_prech", prech, 0);
    rst_n = 1'b0;
    step();
    check_eq("rst_eval_prech", prech, 1);
    check_eq("rst_eval_valid", out_valid, 0);
    check_eq("rst_eval_busy", busy, 0);
    rst_n = 1'b1;
    step();
    run_round(8'h3C, 8'hC3, 8'h00, 8'h3C, 2'b00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
